// File: rtl/dac_shift_autocal.sv
// ---------------------------------------------------------------------------
// dac_shift_autocal
//
// Hardware shift-calibration sequencer for the DAC output path. For every
// channel selected in the latched mask, in ascending order, it routes the
// channel to the static output register and broadcasts a constant target
// word. It then sweeps that channel's shift amount from 0 upward. It stops at
// the first shift where samples WAVE_POS-1, WAVE_POS and WAVE_POS+1 of the
// channel's DAC output word all equal the target. If no shift up to MAX_SHIFT
// locks, the channel is marked failed and its original shift is put back.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   start, abort    run control pulses (abort wins over start)
//   ch_mask, target channel selection and wave value, latched on start
//   dac_tdata       per-channel DAC words, channel c at [c*SAMPLES*SAMPLE_W +: ...]
//   dac_tvalid      per-channel beat valid, paces the settle counter
//   shift_wr_*      manual shift write, honoured only while not busy
//   shift_amt       registered shift per channel, channel c at [c*SHIFT_W +: ...]
//   mux_sel         1 = channel driven from the static output register
//   static_val      latched target while busy, 0 otherwise
//   busy, done      run in progress / one-cycle end-of-run pulse
//   pass_mask       channels that locked in the last run
//   fail_mask       channels that exhausted the sweep in the last run
// ---------------------------------------------------------------------------
module dac_shift_autocal #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLES    = 16,
    parameter int SAMPLE_W   = 16,
    parameter int SHIFT_W    = 4,
    parameter int MAX_SHIFT  = 10,
    parameter int WAVE_POS   = 8,
    parameter int SETTLE_CYC = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic [NUM_CH-1:0]                  ch_mask,
    input  logic [SAMPLE_W-1:0]                target,
    input  logic [NUM_CH*SAMPLES*SAMPLE_W-1:0] dac_tdata,
    input  logic [NUM_CH-1:0]                  dac_tvalid,
    input  logic                               shift_wr_en,
    input  logic [$clog2(NUM_CH)-1:0]          shift_wr_ch,
    input  logic [SHIFT_W-1:0]                 shift_wr_data,
    output logic [NUM_CH*SHIFT_W-1:0]          shift_amt,
    output logic [NUM_CH-1:0]                  mux_sel,
    output logic [SAMPLE_W-1:0]                static_val,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_CH-1:0]                  pass_mask,
    output logic [NUM_CH-1:0]                  fail_mask
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
    localparam int WORD_W = SAMPLES * SAMPLE_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [NUM_CH-1:0]    proc_q, proc_d;
    logic [SAMPLE_W-1:0]  target_q, target_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [SHIFT_W-1:0]   saved_q, saved_d;
    logic [SHIFT_W-1:0]   shift_q [NUM_CH];
    logic [SHIFT_W-1:0]   shift_d [NUM_CH];
    logic [NUM_CH-1:0]    mux_q, mux_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]    pass_q, pass_d;
    logic [NUM_CH-1:0]    fail_q, fail_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [SAMPLE_W-1:0]  static_q, static_d;

    logic [NUM_CH-1:0]    match_vec_s;
    logic [NUM_CH-1:0]    pend_s;
    logic                 seek_hit_s;
    logic [CH_W-1:0]      seek_ch_s;
    logic                 cur_match_s;
    logic                 cur_valid_s;
    logic [SHIFT_W-1:0]   cur_shift_s;
    logic                 settle_end_s;
    logic                 can_step_s;
    logic                 wr_ok_s;
    logic                 unused_tdata_s;

    // Only three samples per channel take part in the comparison.
    assign unused_tdata_s = ^dac_tdata;

    // Per-channel lock detect: the three samples around WAVE_POS equal the target.
    always_comb begin
        match_vec_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match_vec_s[i] = (dac_tdata[i*WORD_W + (WAVE_POS-1)*SAMPLE_W +: SAMPLE_W] == target_q)
                          && (dac_tdata[i*WORD_W +  WAVE_POS   *SAMPLE_W +: SAMPLE_W] == target_q)
                          && (dac_tdata[i*WORD_W + (WAVE_POS+1)*SAMPLE_W +: SAMPLE_W] == target_q);
        end
    end

    // Lowest pending channel: scanning downward leaves the lowest set bit last.
    always_comb begin
        pend_s     = mask_q & ~proc_q;
        seek_hit_s = |pend_s;
        seek_ch_s  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            seek_ch_s = pend_s[i] ? CH_W'(i) : seek_ch_s;
        end
    end

    // Status of the channel currently being swept.
    always_comb begin
        cur_match_s  = match_vec_s[ch_q];
        cur_valid_s  = dac_tvalid[ch_q];
        cur_shift_s  = shift_q[ch_q];
        settle_end_s = cur_valid_s && (cnt_q == CNT_W'(SETTLE_CYC - 1));
        can_step_s   = (cur_shift_s < SHIFT_W'(MAX_SHIFT));
        wr_ok_s      = shift_wr_en && !busy_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; abort returns to IDLE from any active state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_SEEK;
                else                 state_d = ST_IDLE;
            end
            ST_SEEK: begin
                if (abort)           state_d = ST_IDLE;
                else if (seek_hit_s) state_d = ST_SETTLE;
                else                 state_d = ST_FIN;
            end
            ST_SETTLE: begin
                if (abort)             state_d = ST_IDLE;
                else if (settle_end_s) state_d = ST_CHECK;
                else                   state_d = ST_SETTLE;
            end
            ST_CHECK: begin
                if (abort)            state_d = ST_IDLE;
                else if (cur_match_s) state_d = ST_SEEK;
                else if (can_step_s)  state_d = ST_SETTLE;
                else                  state_d = ST_SEEK;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output / datapath next values; outputs describe the state being entered.
    always_comb begin
        mask_d   = mask_q;
        proc_d   = proc_q;
        target_d = target_q;
        ch_d     = ch_q;
        saved_d  = saved_q;
        shift_d  = shift_q;
        mux_d    = mux_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mask_d   = ch_mask;
                    target_d = target;
                    proc_d   = '0;
                    pass_d   = '0;
                    fail_d   = '0;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_SEEK: begin
                if (abort) begin
                    mux_d  = '0;
                    busy_d = 1'b0;
                end else if (seek_hit_s) begin
                    ch_d               = seek_ch_s;
                    saved_d            = shift_q[seek_ch_s];
                    shift_d[seek_ch_s] = '0;
                    mux_d[seek_ch_s]   = 1'b1;
                    proc_d[seek_ch_s]  = 1'b1;
                    cnt_d              = '0;
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    shift_d[ch_q] = saved_q;
                    mux_d         = '0;
                    busy_d        = 1'b0;
                end else if (cur_valid_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    shift_d[ch_q] = saved_q;
                    mux_d         = '0;
                    busy_d        = 1'b0;
                end else if (cur_match_s) begin
                    pass_d[ch_q] = 1'b1;
                    mux_d[ch_q]  = 1'b0;
                end else if (can_step_s) begin
                    shift_d[ch_q] = cur_shift_s + SHIFT_W'(1);
                    cnt_d         = '0;
                end else begin
                    fail_d[ch_q]  = 1'b1;
                    shift_d[ch_q] = saved_q;
                    mux_d[ch_q]   = 1'b0;
                end
            end
            ST_FIN: begin
                busy_d = 1'b0;
            end
            default: begin
                mux_d  = '0;
                busy_d = 1'b0;
            end
        endcase
        // Manual writes only land while no run owns the shift registers.
        for (int i = 0; i < NUM_CH; i++) begin
            shift_d[i] = (wr_ok_s && (shift_wr_ch == CH_W'(i))) ? shift_wr_data : shift_d[i];
        end
        static_d = busy_d ? target_d : '0;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q   <= '0;
            proc_q   <= '0;
            target_q <= '0;
            ch_q     <= '0;
            saved_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shift_q[i] <= '0;
            end
            mux_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            static_q <= '0;
        end else begin
            mask_q   <= mask_d;
            proc_q   <= proc_d;
            target_q <= target_d;
            ch_q     <= ch_d;
            saved_q  <= saved_d;
            shift_q  <= shift_d;
            mux_q    <= mux_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            static_q <= static_d;
        end
    end

    // Pack per-channel shift registers onto the output bus.
    always_comb begin
        shift_amt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            shift_amt[i*SHIFT_W +: SHIFT_W] = shift_q[i];
        end
    end

    assign mux_sel    = mux_q;
    assign static_val = static_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_mask  = pass_q;
    assign fail_mask  = fail_q;

endmodule
